// File: rtl/vga_overlay_mixer.sv
// Pixel compositor: camera window over game image, plus per-frame latched
// tracker markers (crosshair / box / blinking crosshair) with timeout hiding.
module vga_overlay_mixer #(
  parameter int NUM_CURSORS = 2,
  parameter int COORD_W     = 10,
  parameter int THICK       = 1,
  parameter int BOX_HALF    = 8,
  parameter int LOST_FRAMES = 15,
  parameter int BLINK_SHIFT = 4
) (
  input  logic                           vga_clk,
  input  logic                           sys_rst,
  input  logic [COORD_W-1:0]             pix_x,
  input  logic [COORD_W-1:0]             pix_y,
  input  logic                           active_area,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic                           blank_in,
  input  logic [23:0]                    cam_rgb,
  input  logic [15:0]                    game_rgb,
  input  logic [NUM_CURSORS*COORD_W-1:0] pos_x,
  input  logic [NUM_CURSORS*COORD_W-1:0] pos_y,
  input  logic [NUM_CURSORS-1:0]         pos_valid,
  input  logic [NUM_CURSORS*24-1:0]      cursor_color,
  input  logic [1:0]                     mode,
  output logic [7:0]                     vga_red,
  output logic [7:0]                     vga_green,
  output logic [7:0]                     vga_blue,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           blank_out,
  output logic [NUM_CURSORS-1:0]         cursor_hit,
  output logic [NUM_CURSORS-1:0]         cursor_lost
);

  localparam int FW = BLINK_SHIFT + 1;
  localparam logic [COORD_W-1:0] THICK_C = COORD_W'(THICK);
  localparam logic [COORD_W-1:0] BOX_C   = COORD_W'(BOX_HALF);
  localparam logic [7:0]         LOST_C  = 8'(LOST_FRAMES);

  logic                 vs_q;
  logic                 fs;
  logic [FW-1:0]        frame_cnt;
  logic                 blink_on;
  logic [COORD_W-1:0]   shadow_x [NUM_CURSORS];
  logic [COORD_W-1:0]   shadow_y [NUM_CURSORS];
  logic [7:0]           lost_cnt [NUM_CURSORS];
  logic [7:0]           lost_nxt [NUM_CURSORS];

  assign fs       = vs_q & ~vsync_in;
  assign blink_on = frame_cnt[BLINK_SHIFT];

  always_comb begin
    for (int i = 0; i < NUM_CURSORS; i++) begin
      lost_nxt[i] = lost_cnt[i];
      if (fs) begin
        if (pos_valid[i])
          lost_nxt[i] = 8'd0;
        else if (lost_cnt[i] != LOST_C)
          lost_nxt[i] = lost_cnt[i] + 8'd1;
      end
    end
  end

  // cursor_lost tracks the next count so it moves on the fs edge itself
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vs_q        <= 1'b1;
      frame_cnt   <= '0;
      cursor_lost <= '1;
      for (int i = 0; i < NUM_CURSORS; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
        lost_cnt[i] <= LOST_C;
      end
    end else begin
      vs_q <= vsync_in;
      if (fs)
        frame_cnt <= frame_cnt + FW'(1);
      for (int i = 0; i < NUM_CURSORS; i++) begin
        lost_cnt[i]    <= lost_nxt[i];
        cursor_lost[i] <= (lost_nxt[i] == LOST_C);
        if (fs && pos_valid[i]) begin
          shadow_x[i] <= pos_x[i*COORD_W +: COORD_W];
          shadow_y[i] <= pos_y[i*COORD_W +: COORD_W];
        end
      end
    end
  end

  logic signed [COORD_W:0] diff_x [NUM_CURSORS];
  logic signed [COORD_W:0] diff_y [NUM_CURSORS];
  logic [COORD_W-1:0]      dx_c   [NUM_CURSORS];
  logic [COORD_W-1:0]      dy_c   [NUM_CURSORS];

  always_comb begin
    for (int i = 0; i < NUM_CURSORS; i++) begin
      diff_x[i] = $signed({1'b0, pix_x}) - $signed({1'b0, shadow_x[i]});
      diff_y[i] = $signed({1'b0, pix_y}) - $signed({1'b0, shadow_y[i]});
      dx_c[i]   = diff_x[i][COORD_W] ? COORD_W'(-diff_x[i])
                                     : diff_x[i][COORD_W-1:0];
      dy_c[i]   = diff_y[i][COORD_W] ? COORD_W'(-diff_y[i])
                                     : diff_y[i][COORD_W-1:0];
    end
  end

  logic [COORD_W-1:0] s1_dx [NUM_CURSORS];
  logic [COORD_W-1:0] s1_dy [NUM_CURSORS];
  logic               s1_active;
  logic               s1_hs;
  logic               s1_vs;
  logic               s1_blank;
  logic [23:0]        s1_cam;
  logic [15:0]        s1_game;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_active <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_blank  <= 1'b0;
      s1_cam    <= '0;
      s1_game   <= '0;
      for (int i = 0; i < NUM_CURSORS; i++) begin
        s1_dx[i] <= '0;
        s1_dy[i] <= '0;
      end
    end else begin
      s1_active <= active_area;
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
      s1_blank  <= blank_in;
      s1_cam    <= cam_rgb;
      s1_game   <= game_rgb;
      for (int i = 0; i < NUM_CURSORS; i++) begin
        s1_dx[i] <= dx_c[i];
        s1_dy[i] <= dy_c[i];
      end
    end
  end

  logic [NUM_CURSORS-1:0] hit_c;
  logic [23:0]            col_c;
  logic                   shape;
  logic                   xhair;
  logic                   box;

  always_comb begin
    hit_c = '0;
    shape = 1'b0;
    xhair = 1'b0;
    box   = 1'b0;
    for (int i = 0; i < NUM_CURSORS; i++) begin
      xhair = (s1_dx[i] <= THICK_C) || (s1_dy[i] <= THICK_C);
      box   = ((s1_dx[i] == BOX_C) && (s1_dy[i] <= BOX_C)) ||
              ((s1_dy[i] == BOX_C) && (s1_dx[i] <= BOX_C));
      shape = (mode == 2'd2) ? box : xhair;
      hit_c[i] = (mode != 2'd0) && s1_active && !cursor_lost[i] &&
                 ((mode != 2'd3) || blink_on) && shape;
    end
  end

  // walk downward so the lowest-index hit wins
  always_comb begin
    col_c = s1_active ? s1_cam
                      : {s1_game[15:11], s1_game[15:13],
                         s1_game[10:5],  s1_game[10:9],
                         s1_game[4:0],   s1_game[4:2]};
    for (int i = NUM_CURSORS - 1; i >= 0; i--)
      if (hit_c[i])
        col_c = cursor_color[i*24 +: 24];
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vga_red    <= '0;
      vga_green  <= '0;
      vga_blue   <= '0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
      blank_out  <= 1'b0;
      cursor_hit <= '0;
    end else begin
      vga_red    <= col_c[23:16];
      vga_green  <= col_c[15:8];
      vga_blue   <= col_c[7:0];
      hsync_out  <= s1_hs;
      vsync_out  <= s1_vs;
      blank_out  <= s1_blank;
      cursor_hit <= hit_c;
    end
  end

endmodule

// File: tb/tb_vga_overlay_mixer.sv
// Directed bench for vga_overlay_mixer: vector table for the mux and
// crosshair shapes, hand sequences for frame latching, box, blink, timeout.
module tb_vga_overlay_mixer;

  logic        vga_clk = 1'b0;
  logic        sys_rst;
  logic [9:0]  pix_x, pix_y;
  logic        active_area;
  logic        hsync_in, vsync_in, blank_in;
  logic [23:0] cam_rgb;
  logic [15:0] game_rgb;
  logic [19:0] pos_x, pos_y;
  logic [1:0]  pos_valid;
  logic [47:0] cursor_color;
  logic [1:0]  mode;
  logic [7:0]  vga_red, vga_green, vga_blue;
  logic        hsync_out, vsync_out, blank_out;
  logic [1:0]  cursor_hit, cursor_lost;

  int n_vec = 0;
  int n_bad = 0;
  int fs_count = 0;
  logic [1:0] lost_s;

  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] CAM = 24'h123456;

  always #5 vga_clk = ~vga_clk;

  vga_overlay_mixer dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst),
    .pix_x(pix_x), .pix_y(pix_y), .active_area(active_area),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .cam_rgb(cam_rgb), .game_rgb(game_rgb),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
    .cursor_color(cursor_color), .mode(mode),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
    .cursor_hit(cursor_hit), .cursor_lost(cursor_lost)
  );

  typedef struct {
    logic [9:0]  x, y;
    logic        act;
    logic [15:0] game;
    logic [1:0]  md;
    logic [23:0] rgb;
    logic [1:0]  hit;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [9:0] x, input logic [9:0] y,
                       input logic a, input logic [15:0] g);
    @(posedge vga_clk); #1;
    pix_x = x; pix_y = y; active_area = a;
    cam_rgb = CAM; game_rgb = g;
    @(posedge vga_clk);
    @(posedge vga_clk); #1;
  endtask

  task automatic pix_chk(input string name, input logic [9:0] x,
                         input logic [9:0] y, input logic [23:0] rgb,
                         input logic [1:0] hit);
    apply(x, y, 1'b1, 16'h0000);
    chk({name, " rgb"}, {8'h0, vga_red, vga_green, vga_blue}, {8'h0, rgb});
    chk({name, " hit"}, {30'h0, cursor_hit}, {30'h0, hit});
  endtask

  task automatic fs_pulse();
    @(posedge vga_clk); #1 vsync_in = 1'b0;
    @(posedge vga_clk); #1 lost_s = cursor_lost;
    vsync_in = 1'b1;
    @(posedge vga_clk); #1;
    fs_count++;
  endtask

  task automatic set_pos(input logic [9:0] x0, input logic [9:0] y0,
                         input logic [9:0] x1, input logic [9:0] y1);
    pos_x = {x1, x0};
    pos_y = {y1, y0};
  endtask

  vec_t tbl[12];
  logic [23:0] lat_cam [6];
  logic [2:0]  lat_sig [6];

  initial begin
    tbl[0]  = '{10'd100, 10'd10,  1'b1, 16'h0000, 2'd1, RED, 2'b11};
    tbl[1]  = '{10'd99,  10'd300, 1'b1, 16'h0000, 2'd1, RED, 2'b11};
    tbl[2]  = '{10'd98,  10'd300, 1'b1, 16'h0000, 2'd1, CAM, 2'b00};
    tbl[3]  = '{10'd300, 10'd51,  1'b1, 16'h0000, 2'd1, RED, 2'b01};
    tbl[4]  = '{10'd300, 10'd52,  1'b1, 16'h0000, 2'd1, CAM, 2'b00};
    tbl[5]  = '{10'd300, 10'd200, 1'b1, 16'h0000, 2'd1, GRN, 2'b10};
    tbl[6]  = '{10'd100, 10'd200, 1'b1, 16'h0000, 2'd1, RED, 2'b11};
    tbl[7]  = '{10'd100, 10'd50,  1'b0, 16'h001F, 2'd1, 24'h0000FF, 2'b00};
    tbl[8]  = '{10'd300, 10'd300, 1'b0, 16'hF800, 2'd1, 24'hFF0000, 2'b00};
    tbl[9]  = '{10'd300, 10'd300, 1'b0, 16'h8410, 2'd1, 24'h848284, 2'b00};
    tbl[10] = '{10'd100, 10'd50,  1'b1, 16'h0000, 2'd0, CAM, 2'b00};
    tbl[11] = '{10'd102, 10'd48,  1'b1, 16'h0000, 2'd1, CAM, 2'b00};

    sys_rst = 1'b1;
    pix_x = '0; pix_y = '0; active_area = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b0;
    cam_rgb = '0; game_rgb = '0;
    pos_x = '0; pos_y = '0; pos_valid = 2'b00;
    cursor_color = {GRN, RED};
    mode = 2'd1;

    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst rgb", {8'h0, vga_red, vga_green, vga_blue}, 32'h0);
    chk("rst syncs", {29'h0, hsync_out, vsync_out, blank_out}, 32'h6);
    chk("rst hit", {30'h0, cursor_hit}, 32'h0);
    chk("rst lost", {30'h0, cursor_lost}, 32'h3);
    sys_rst = 1'b0;

    fs_pulse();
    chk("lost held", {30'h0, lost_s}, 32'h3);
    pix_chk("lost cam", 10'd0, 10'd0, CAM, 2'b00);
    apply(10'd0, 10'd0, 1'b0, 16'hF800);
    chk("lost game", {8'h0, vga_red, vga_green, vga_blue}, 32'hFF0000);

    set_pos(10'd100, 10'd50, 10'd100, 10'd200);
    pos_valid = 2'b11;
    fs_pulse();
    chk("valid clears lost", {30'h0, lost_s}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      mode = tbl[i].md;
      apply(tbl[i].x, tbl[i].y, tbl[i].act, tbl[i].game);
      chk($sformatf("vec%0d rgb", i),
          {8'h0, vga_red, vga_green, vga_blue}, {8'h0, tbl[i].rgb});
      chk($sformatf("vec%0d hit", i),
          {30'h0, cursor_hit}, {30'h0, tbl[i].hit});
    end

    // latency: stream one pixel per cycle, expect it two cycles later
    mode = 2'd0;
    for (int k = 0; k < 6; k++) begin
      lat_cam[k] = 24'hA00000 + 24'(k * 24'h010203);
      lat_sig[k] = 3'(k + 1);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge vga_clk); #1;
      if (k >= 2) begin
        chk($sformatf("lat%0d rgb", k - 2),
            {8'h0, vga_red, vga_green, vga_blue}, {8'h0, lat_cam[k-2]});
        chk($sformatf("lat%0d hs/bl", k - 2),
            {30'h0, hsync_out, blank_out},
            {30'h0, lat_sig[k-2][0], lat_sig[k-2][1]});
      end
      if (k < 6) begin
        active_area = 1'b1;
        cam_rgb  = lat_cam[k];
        hsync_in = lat_sig[k][0];
        blank_in = lat_sig[k][1];
      end
    end
    hsync_in = 1'b1; blank_in = 1'b0;
    mode = 2'd1;

    // live position ignored until the next frame strobe
    set_pos(10'd400, 10'd50, 10'd100, 10'd200);
    pix_chk("mid pre a", 10'd100, 10'd10, RED, 2'b11);
    pix_chk("mid pre b", 10'd400, 10'd300, CAM, 2'b00);
    fs_pulse();
    pix_chk("mid post a", 10'd100, 10'd10, GRN, 2'b10);
    pix_chk("mid post b", 10'd400, 10'd300, RED, 2'b01);

    // box outline
    set_pos(10'd320, 10'd240, 10'd100, 10'd200);
    fs_pulse();
    mode = 2'd2;
    pix_chk("box left", 10'd312, 10'd240, RED, 2'b01);
    pix_chk("box corner", 10'd328, 10'd232, RED, 2'b01);
    pix_chk("box centre", 10'd320, 10'd240, CAM, 2'b00);
    pix_chk("box outside", 10'd329, 10'd240, CAM, 2'b00);

    // blinking crosshair follows frame counter bit 4
    mode = 2'd3;
    for (int n = 0; n < 32 && fs_count[4] != 1'b0; n++) fs_pulse();
    pix_chk("blink off", 10'd320, 10'd100, CAM, 2'b00);
    for (int n = 0; n < 32 && fs_count[4] != 1'b1; n++) fs_pulse();
    pix_chk("blink on", 10'd320, 10'd100, RED, 2'b01);
    mode = 2'd1;

    // timeout on channel 0
    pos_valid = 2'b10;
    for (int n = 1; n <= 14; n++) fs_pulse();
    chk("lost after 14", {30'h0, lost_s}, 32'h0);
    fs_pulse();
    chk("lost after 15", {30'h0, lost_s}, 32'h1);
    pix_chk("lost hidden", 10'd320, 10'd100, CAM, 2'b00);
    pos_valid = 2'b11;
    set_pos(10'd300, 10'd60, 10'd100, 10'd200);
    fs_pulse();
    chk("lost cleared", {30'h0, lost_s}, 32'h0);
    pix_chk("redisplay", 10'd300, 10'd300, RED, 2'b01);

    // mid-frame reset
    @(posedge vga_clk); #3;
    sys_rst = 1'b1;
    #2;
    chk("mrst lost", {30'h0, cursor_lost}, 32'h3);
    chk("mrst rgb", {8'h0, vga_red, vga_green, vga_blue}, 32'h0);
    chk("mrst vs", {31'h0, vsync_out}, 32'h1);
    @(posedge vga_clk); #1 sys_rst = 1'b0;
    fs_count = 0;
    pix_chk("post rst hidden", 10'd300, 10'd300, CAM, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
